// File: rtl/seu_err_monitor.sv
// SEU error monitor: rising-edge detection of voter corrected/uncorrected error lines,
// saturating event counters, sticky flags, first-uncorrectable capture and an acknowledged level IRQ.
module seu_err_monitor #(
  parameter int N_SRC     = 4,
  parameter int CNT_WIDTH = 16,
  parameter int THRESH    = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [N_SRC-1:0]     error1_i,
  input  logic [N_SRC-1:0]     error2_i,
  input  logic                 clear_i,
  input  logic                 ack_i,
  output logic [CNT_WIDTH-1:0] cnt1_o,
  output logic [CNT_WIDTH-1:0] cnt2_o,
  output logic [N_SRC-1:0]     sticky1_o,
  output logic [N_SRC-1:0]     sticky2_o,
  output logic                 first_vld_o,
  output logic [4:0]           first_src_o,
  output logic                 irq_o,
  output logic                 sat_o
);

  // Sum width must hold the counter plus a popcount of up to 32 sources without wrapping.
  localparam int SW = ((CNT_WIDTH > 6) ? CNT_WIDTH : 6) + 1;
  localparam logic [SW-1:0] CNT_MAX  = {{(SW-CNT_WIDTH){1'b0}}, {CNT_WIDTH{1'b1}}};
  localparam logic [SW-1:0] THRESH_W = SW'(THRESH);

  typedef enum logic [1:0] {IDLE, ALERT, HOLD} state_t;

  logic [N_SRC-1:0]     err1_prev_q, err2_prev_q;
  logic [N_SRC-1:0]     ev1_q, ev2_q;
  logic [CNT_WIDTH-1:0] cnt1_q, cnt2_q;
  logic [CNT_WIDTH-1:0] cnt1_d, cnt2_d;
  logic [N_SRC-1:0]     sticky1_q, sticky2_q;
  logic                 sat_q;
  logic                 first_vld_q;
  logic [4:0]           first_src_q;
  logic [4:0]           low_idx;
  logic [SW-1:0]        sum1, sum2;
  logic                 ovf1, ovf2;
  logic                 trig;
  state_t               state_q;
  logic                 pend_q;

  function automatic logic [5:0] popcnt(input logic [N_SRC-1:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < N_SRC; i++) c = c + {5'b0, v[i]};
    return c;
  endfunction

  always_comb begin
    sum1    = (clear_i ? '0 : {{(SW-CNT_WIDTH){1'b0}}, cnt1_q}) + SW'(popcnt(ev1_q));
    sum2    = (clear_i ? '0 : {{(SW-CNT_WIDTH){1'b0}}, cnt2_q}) + SW'(popcnt(ev2_q));
    ovf1    = (sum1 > CNT_MAX);
    ovf2    = (sum2 > CNT_MAX);
    cnt1_d  = ovf1 ? {CNT_WIDTH{1'b1}} : sum1[CNT_WIDTH-1:0];
    cnt2_d  = ovf2 ? {CNT_WIDTH{1'b1}} : sum2[CNT_WIDTH-1:0];
    // Threshold crossing compares the clamped next value against the current value.
    trig    = (|ev2_q) ||
              (({{(SW-CNT_WIDTH){1'b0}}, cnt1_d} >= THRESH_W) &&
               ({{(SW-CNT_WIDTH){1'b0}}, cnt1_q} <  THRESH_W));
    low_idx = '0;
    for (int i = N_SRC-1; i >= 0; i--) begin
      if (ev2_q[i]) low_idx = 5'(i);
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err1_prev_q <= '0;
      err2_prev_q <= '0;
      ev1_q       <= '0;
      ev2_q       <= '0;
      cnt1_q      <= '0;
      cnt2_q      <= '0;
      sticky1_q   <= '0;
      sticky2_q   <= '0;
      sat_q       <= 1'b0;
      first_vld_q <= 1'b0;
      first_src_q <= '0;
    end else begin
      err1_prev_q <= error1_i;
      err2_prev_q <= error2_i;
      ev1_q       <= error1_i & ~err1_prev_q;
      ev2_q       <= error2_i & ~err2_prev_q;
      cnt1_q      <= cnt1_d;
      cnt2_q      <= cnt2_d;
      // clear_i restarts accumulation from this cycle's events rather than dropping them.
      sticky1_q   <= (clear_i ? '0 : sticky1_q) | ev1_q;
      sticky2_q   <= (clear_i ? '0 : sticky2_q) | ev2_q;
      sat_q       <= (clear_i ? 1'b0 : sat_q) | ovf1 | ovf2;
      if (clear_i) begin
        first_vld_q <= |ev2_q;
        first_src_q <= low_idx;
      end else if (!first_vld_q && (|ev2_q)) begin
        first_vld_q <= 1'b1;
        first_src_q <= low_idx;
      end
    end
  end

  // HOLD waits for ack release; triggers seen while held are replayed as a new ALERT.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      pend_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE:  if (trig) state_q <= ALERT;
        ALERT: if (ack_i) begin
          state_q <= HOLD;
          pend_q  <= 1'b0;
        end
        HOLD: begin
          if (!ack_i) begin
            state_q <= (pend_q || trig) ? ALERT : IDLE;
            pend_q  <= 1'b0;
          end else if (trig) begin
            pend_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cnt1_o      = cnt1_q;
  assign cnt2_o      = cnt2_q;
  assign sticky1_o   = sticky1_q;
  assign sticky2_o   = sticky2_q;
  assign sat_o       = sat_q;
  assign first_vld_o = first_vld_q;
  assign first_src_o = first_src_q;
  assign irq_o       = (state_q == ALERT);

endmodule

// File: tb/tb_seu_err_monitor.sv
// Bench for seu_err_monitor: directed scenarios plus randomized traffic against a behavioural model,
// run on a default instance (16-bit counters) and a narrow instance (4-bit counters) sharing inputs.
module tb_seu_err_monitor;

  logic        clk = 1'b0;
  logic        rstn;
  logic [3:0]  error1, error2;
  logic        clear, ack;

  logic [15:0] a_cnt1, a_cnt2;
  logic [3:0]  b_cnt1, b_cnt2;
  logic [3:0]  a_st1, a_st2, b_st1, b_st2;
  logic        a_fv, b_fv, a_irq, b_irq, a_sat, b_sat;
  logic [4:0]  a_fs, b_fs;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  seu_err_monitor #(.N_SRC(4), .CNT_WIDTH(16), .THRESH(8)) dut_a (
    .clk_i(clk), .rstn_i(rstn), .error1_i(error1), .error2_i(error2),
    .clear_i(clear), .ack_i(ack), .cnt1_o(a_cnt1), .cnt2_o(a_cnt2),
    .sticky1_o(a_st1), .sticky2_o(a_st2), .first_vld_o(a_fv),
    .first_src_o(a_fs), .irq_o(a_irq), .sat_o(a_sat));

  seu_err_monitor #(.N_SRC(4), .CNT_WIDTH(4), .THRESH(8)) dut_b (
    .clk_i(clk), .rstn_i(rstn), .error1_i(error1), .error2_i(error2),
    .clear_i(clear), .ack_i(ack), .cnt1_o(b_cnt1), .cnt2_o(b_cnt2),
    .sticky1_o(b_st1), .sticky2_o(b_st2), .first_vld_o(b_fv),
    .first_src_o(b_fs), .irq_o(b_irq), .sat_o(b_sat));

  // Behavioural model: index 0 tracks dut_a, index 1 tracks dut_b.
  int          m_max[2] = '{65535, 15};
  int          m_cnt1[2], m_cnt2[2], m_fs[2];
  int          m_mode[2];  // 0 quiet, 1 alerting, 2 acknowledged
  bit          m_pend[2], m_sat[2], m_fv[2];
  logic [3:0]  m_st1[2], m_st2[2];
  logic [3:0]  m_last1, m_last2, m_new1, m_new2;
  int          t_n1, t_n2, t_low;
  bit          t_over, t_trig;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin
        m_cnt1[k] = 0; m_cnt2[k] = 0; m_fs[k] = 0; m_mode[k] = 0;
        m_pend[k] = 0; m_sat[k] = 0; m_fv[k] = 0; m_st1[k] = 0; m_st2[k] = 0;
      end
      m_last1 = 0; m_last2 = 0; m_new1 = 0; m_new2 = 0;
    end else begin
      t_low = 0;
      for (int j = 3; j >= 0; j--) if (m_new2[j]) t_low = j;
      for (int k = 0; k < 2; k++) begin
        t_n1 = (clear ? 0 : m_cnt1[k]) + $countones(m_new1);
        t_n2 = (clear ? 0 : m_cnt2[k]) + $countones(m_new2);
        t_over = (t_n1 > m_max[k]) || (t_n2 > m_max[k]);
        if (t_n1 > m_max[k]) t_n1 = m_max[k];
        if (t_n2 > m_max[k]) t_n2 = m_max[k];
        t_trig = (m_new2 != 0) || (t_n1 >= 8 && m_cnt1[k] < 8);
        case (m_mode[k])
          0: if (t_trig) m_mode[k] = 1;
          1: if (ack) begin m_mode[k] = 2; m_pend[k] = 0; end
          default: begin
            if (t_trig) m_pend[k] = 1;
            if (!ack) begin m_mode[k] = m_pend[k] ? 1 : 0; m_pend[k] = 0; end
          end
        endcase
        m_st1[k] = (clear ? 4'b0 : m_st1[k]) | m_new1;
        m_st2[k] = (clear ? 4'b0 : m_st2[k]) | m_new2;
        m_sat[k] = (clear ? 1'b0 : m_sat[k]) | t_over;
        if (clear || (!m_fv[k] && m_new2 != 0)) begin
          m_fv[k] = (m_new2 != 0);
          m_fs[k] = t_low;
        end
        m_cnt1[k] = t_n1;
        m_cnt2[k] = t_n2;
      end
      m_new1 = error1 & ~m_last1; m_last1 = error1;
      m_new2 = error2 & ~m_last2; m_last2 = error2;
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    rstn = 1'b0; error1 = 0; error2 = 0; clear = 0; ack = 0;
    step(2);
    n_checks++;
    if ({a_cnt1, a_cnt2, a_st1, a_st2, a_fv, a_fs, a_irq, a_sat} !== '0) begin
      n_fail++; $display("FAIL reset_a: outputs %h, required 0", {a_cnt1, a_cnt2, a_st1, a_st2, a_fv, a_fs, a_irq, a_sat});
    end
    rstn = 1'b1;
    step(2);
    n_checks++;
    if ({b_cnt1, b_cnt2, b_st1, b_st2, b_fv, b_fs, b_irq, b_sat} !== '0) begin
      n_fail++; $display("FAIL reset_b: outputs %h, required 0", {b_cnt1, b_cnt2, b_st1, b_st2, b_fv, b_fs, b_irq, b_sat});
    end
  endtask

  task automatic test_single_pulse;
    error1 = 4'b0100; step(1); error1 = 0; step(1);
    n_checks++;
    if (a_cnt1 !== 16'd1 || a_st1 !== 4'b0100 || a_irq !== 1'b0 || a_cnt2 !== 16'd0) begin
      n_fail++; $display("FAIL single_pulse: cnt1=%0d st1=%b irq=%b cnt2=%0d, required 1 0100 0 0", a_cnt1, a_st1, a_irq, a_cnt2);
    end
  endtask

  task automatic test_threshold;
    clear = 1; step(1); clear = 0;
    error1 = 4'b0001; step(10); error1 = 0; step(2);
    n_checks++;
    if (a_cnt1 !== 16'd1) begin
      n_fail++; $display("FAIL held_line: cnt1=%0d, required 1", a_cnt1);
    end
    for (int p = 2; p <= 8; p++) begin
      error1 = 4'b0001; step(1); error1 = 0; step(1);
      n_checks++;
      if (a_cnt1 !== 16'(p) || a_irq !== (p >= 8)) begin
        n_fail++; $display("FAIL thresh_pulse%0d: cnt1=%0d irq=%b, required %0d %b", p, a_cnt1, a_irq, p, p >= 8);
      end
    end
    ack = 1; step(1);
    n_checks++;
    if (a_irq !== 1'b0) begin n_fail++; $display("FAIL ack_drop: irq=%b, required 0", a_irq); end
    ack = 0; step(2);
    n_checks++;
    if (a_irq !== 1'b0) begin n_fail++; $display("FAIL ack_release: irq=%b, required 0", a_irq); end
  endtask

  task automatic test_uncorrected;
    clear = 1; step(1); clear = 0;
    error2 = 4'b1010; step(1); error2 = 0; step(1);
    n_checks++;
    if (a_cnt2 !== 16'd2 || a_fv !== 1'b1 || a_fs !== 5'd1 || a_irq !== 1'b1 || a_st2 !== 4'b1010) begin
      n_fail++; $display("FAIL err2_pair: cnt2=%0d fv=%b fs=%0d irq=%b st2=%b, required 2 1 1 1 1010", a_cnt2, a_fv, a_fs, a_irq, a_st2);
    end
    error2 = 4'b0001; step(1); error2 = 0; step(1);
    n_checks++;
    if (a_cnt2 !== 16'd3 || a_fs !== 5'd1) begin
      n_fail++; $display("FAIL first_hold: cnt2=%0d fs=%0d, required 3 1", a_cnt2, a_fs);
    end
    ack = 1; step(1); ack = 0; step(1);
  endtask

  task automatic test_saturation;
    clear = 1; step(1); clear = 0;
    repeat (5) begin error1 = 4'b1111; step(1); error1 = 0; step(1); end
    n_checks++;
    if (b_cnt1 !== 4'd15 || b_sat !== 1'b1 || a_cnt1 !== 16'd20 || a_sat !== 1'b0) begin
      n_fail++; $display("FAIL saturate: b_cnt1=%0d b_sat=%b a_cnt1=%0d a_sat=%b, required 15 1 20 0", b_cnt1, b_sat, a_cnt1, a_sat);
    end
    clear = 1; step(1); clear = 0;
    n_checks++;
    if (b_cnt1 !== 4'd0 || b_sat !== 1'b0) begin
      n_fail++; $display("FAIL sat_clear: cnt1=%0d sat=%b, required 0 0", b_cnt1, b_sat);
    end
    ack = 1; step(1); ack = 0; step(1);
  endtask

  task automatic test_clear_coincident;
    clear = 1; step(1); clear = 0;
    error1 = 4'b0111; step(1); error1 = 0; step(1);
    error1 = 4'b1000; step(1); error1 = 0; clear = 1; step(1); clear = 0;
    n_checks++;
    if (a_cnt1 !== 16'd1 || a_st1 !== 4'b1000) begin
      n_fail++; $display("FAIL clear_edge: cnt1=%0d st1=%b, required 1 1000", a_cnt1, a_st1);
    end
    error2 = 4'b0100; step(1); error2 = 0; step(1);
    n_checks++;
    if (a_irq !== 1'b1 || a_fs !== 5'd2) begin
      n_fail++; $display("FAIL err2_irq: irq=%b fs=%0d, required 1 2", a_irq, a_fs);
    end
    clear = 1; step(1); clear = 0; step(3);
    n_checks++;
    if (a_irq !== 1'b1 || a_fv !== 1'b0 || a_cnt2 !== 16'd0) begin
      n_fail++; $display("FAIL clear_keeps_irq: irq=%b fv=%b cnt2=%0d, required 1 0 0", a_irq, a_fv, a_cnt2);
    end
    ack = 1; step(1); ack = 0; step(1);
    n_checks++;
    if (a_irq !== 1'b0) begin n_fail++; $display("FAIL ack_after_clear: irq=%b, required 0", a_irq); end
  endtask

  task automatic test_async_reset;
    clear = 1; step(1); clear = 0;
    repeat (2) begin error1 = 4'b0001; step(1); error1 = 0; step(1); end
    error1 = 4'b0010;
    @(posedge clk); #2; rstn = 1'b0; #1;
    n_checks++;
    if ({a_cnt1, a_cnt2, a_st1, a_st2, a_fv, a_fs, a_irq, a_sat, b_cnt1, b_st1} !== '0) begin
      n_fail++; $display("FAIL async_reset: outputs %h, required 0", {a_cnt1, a_cnt2, a_st1, a_st2, a_fv, a_fs, a_irq, a_sat, b_cnt1, b_st1});
    end
    error1 = 0;
    @(negedge clk); rstn = 1'b1;
    error2 = 4'b0010; step(6);
    n_checks++;
    if (a_cnt2 !== 16'd1 || a_fv !== 1'b1 || a_fs !== 5'd1 || a_irq !== 1'b1 || a_cnt1 !== 16'd0) begin
      n_fail++; $display("FAIL hold_after_reset: cnt2=%0d fv=%b fs=%0d irq=%b cnt1=%0d, required 1 1 1 1 0", a_cnt2, a_fv, a_fs, a_irq, a_cnt1);
    end
    error2 = 0; ack = 1; step(1); ack = 0; step(1);
  endtask

  task automatic test_random;
    logic [15:0] act_c1[2], act_c2[2];
    logic [3:0]  act_s1[2], act_s2[2];
    logic [4:0]  act_fs[2];
    logic        act_fv[2], act_irq[2], act_sat[2];
    for (int cyc = 0; cyc < 600; cyc++) begin
      act_c1 = '{a_cnt1, {12'b0, b_cnt1}}; act_c2 = '{a_cnt2, {12'b0, b_cnt2}};
      act_s1 = '{a_st1, b_st1}; act_s2 = '{a_st2, b_st2}; act_fs = '{a_fs, b_fs};
      act_fv = '{a_fv, b_fv}; act_irq = '{a_irq, b_irq}; act_sat = '{a_sat, b_sat};
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (act_c1[k] !== 16'(m_cnt1[k]) || act_c2[k] !== 16'(m_cnt2[k]) ||
            act_s1[k] !== m_st1[k] || act_s2[k] !== m_st2[k] || act_fv[k] !== m_fv[k] ||
            (m_fv[k] && act_fs[k] !== 5'(m_fs[k])) || act_irq[k] !== (m_mode[k] == 1) ||
            act_sat[k] !== m_sat[k]) begin
          n_fail++;
          $display("FAIL random_c%0d_dut%0d: got c1=%0d c2=%0d s1=%b s2=%b fv=%b fs=%0d irq=%b sat=%b, required %0d %0d %b %b %b %0d %b %b",
                   cyc, k, act_c1[k], act_c2[k], act_s1[k], act_s2[k], act_fv[k], act_fs[k], act_irq[k], act_sat[k],
                   m_cnt1[k], m_cnt2[k], m_st1[k], m_st2[k], m_fv[k], m_fs[k], m_mode[k] == 1, m_sat[k]);
        end
      end
      error1 = 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      error2 = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      clear  = ($urandom_range(0, 24) == 0);
      ack    = ($urandom_range(0, 2) == 0);
      step(1);
    end
    error1 = 0; error2 = 0; clear = 0; ack = 0;
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_threshold();
    test_uncorrected();
    test_saturation();
    test_clear_coincident();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
